// File: rtl/hack_pkg.sv
// hack_pkg: constants and types shared across the Hack datapath blocks.
//   WORD_WIDTH        native datapath word width
//   MSB_FIRST_ORDER   first serial bit lands in the word MSB
//   LSB_FIRST_ORDER   first serial bit lands in the word LSB
//   dsr_state_t       observable state of the serial word deserializer
package hack_pkg;

  localparam int WORD_WIDTH      = 16;
  localparam bit MSB_FIRST_ORDER = 1'b1;
  localparam bit LSB_FIRST_ORDER = 1'b0;

  // FILLING: no word held. HOLDING: word held, assembly continues.
  // STALLED: word held, assembly full up to the completing bit, downstream not ready.
  typedef enum logic [1:0] {
    ST_FILLING = 2'd0,
    ST_HOLDING = 2'd1,
    ST_STALLED = 2'd2
  } dsr_state_t;

endpackage

// File: rtl/serial_word_deserializer_if.sv
// serial_word_deserializer_if: bit-in / word-out handshake bundle.
//   clear, in_valid, in_bit, out_ready   driven by the environment (master)
//   in_ready, out_valid, out_word,
//   bit_count, state                     driven by the deserializer (slave)
// Handshake: a bit moves when in_valid && in_ready at a rising edge; a word
// moves when out_valid && out_ready at a rising edge. A source holds its
// payload stable while valid is high and ready is low.
interface serial_word_deserializer_if
  import hack_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) ();

  localparam int CW = $clog2(WIDTH);

  logic             clear;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_word;
  logic             out_ready;
  logic [CW-1:0]    bit_count;
  dsr_state_t       state;

  modport master (
    output clear, in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_word, bit_count, state
  );

  modport slave (
    input  clear, in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_word, bit_count, state
  );

endinterface

// File: rtl/serial_word_deserializer_shift_reg_in.sv
// shift_reg_in: WIDTH-bit serial-in shift register.
//   clk, rst   clock, asynchronous active-high reset
//   shift_en   shift din in this cycle
//   clear      synchronous zero; wins over shift_en
//   din        serial input bit
//   shifted    register contents with din already shifted in, so the owner
//              can capture a word that includes the bit arriving this cycle
module shift_reg_in #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             din,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] q;

  // MSB-first shifts toward the MSB so the oldest bit ends up on top;
  // LSB-first shifts toward the LSB so the oldest bit ends up in bit 0.
  always_comb begin
    if (MSB_FIRST) shifted = {q[WIDTH-2:0], din};
    else           shifted = {din, q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           q <= '0;
    else if (clear)    q <= '0;
    else if (shift_en) q <= shifted;
  end

endmodule

// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer: assembles a handshaked bit stream into WIDTH-bit
// words and presents them through a one-word output register.
//   clk, rst   clock, asynchronous active-high reset
//   bus        serial_word_deserializer_if slave: clear, in_valid/in_bit/
//              in_ready, out_valid/out_word/out_ready, bit_count, state
// Only the completing bit can stall: in_ready drops when the assembly needs
// one more bit, a word is still held and downstream is not taking it.
module serial_word_deserializer
  import hack_pkg::*;
#(
  parameter int WIDTH     = WORD_WIDTH,
  parameter bit MSB_FIRST = MSB_FIRST_ORDER
) (
  input logic                        clk,
  input logic                        rst,
  serial_word_deserializer_if.slave  bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    bit_count_q, bit_count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_word_q,  out_word_d;
  logic [WIDTH-1:0] sr_shifted;
  logic             in_ready_c;
  logic             accept;
  logic             complete;
  dsr_state_t       state_c;

  shift_reg_in #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .clear    (bus.clear | complete),
    .din      (bus.in_bit),
    .shifted  (sr_shifted)
  );

  always_comb begin
    in_ready_c  = !((bit_count_q == LAST) && out_valid_q && !bus.out_ready);
    // A bit handshaked in the same cycle as clear is dropped.
    accept      = bus.in_valid && in_ready_c && !bus.clear;
    complete    = accept && (bit_count_q == LAST);

    bit_count_d = bit_count_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;

    if (bus.clear)   bit_count_d = '0;
    else if (accept) bit_count_d = complete ? '0 : bit_count_q + CW'(1);

    // A completing bit reloads the register even while the old word leaves,
    // so back-to-back words see no bubble.
    if (complete) begin
      out_valid_d = 1'b1;
      out_word_d  = sr_shifted;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (!out_valid_q)       state_c = ST_FILLING;
    else if (!in_ready_c)   state_c = ST_STALLED;
    else                    state_c = ST_HOLDING;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_count_q <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      bit_count_q <= bit_count_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.bit_count = bit_count_q;
  assign bus.state     = state_c;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Bench for serial_word_deserializer: directed words through an MSB-first
// instance checked by a scoreboard, plus an LSB-first instance.
module tb_serial_word_deserializer;
  import hack_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  serial_word_deserializer_if #(.WIDTH(W)) sif ();
  serial_word_deserializer_if #(.WIDTH(W)) lif ();

  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk (clk), .rst (rst), .bus (sif)
  );

  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk (clk), .rst (rst), .bus (lif)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  int xfer_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int budget;
    budget = 0;
    sif.in_valid = 1'b1;
    sif.in_bit   = b;
    while (!sif.in_ready && budget < 50) begin
      tick();
      budget++;
    end
    if (!sif.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready=0 after 50 cycles, required 1");
    end
    tick();
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit expect_out);
    if (expect_out) exp_q.push_back(w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && sif.out_valid && sif.out_ready) begin
      xfer_cyc.push_back(cycle_cnt);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%0h, required no word", sif.out_word);
      end else begin
        check("scoreboard_word", 32'(sif.out_word), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    sif.clear = 1'b0; sif.in_valid = 1'b0; sif.in_bit = 1'b0; sif.out_ready = 1'b0;
    lif.clear = 1'b0; lif.in_valid = 1'b0; lif.in_bit = 1'b0; lif.out_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();

    // reset values
    check("rst_in_ready",  32'(sif.in_ready),  32'd1);
    check("rst_out_valid", 32'(sif.out_valid), 32'd0);
    check("rst_out_word",  32'(sif.out_word),  32'd0);
    check("rst_bit_count", 32'(sif.bit_count), 32'd0);
    check("rst_state",     32'(sif.state),     32'(ST_FILLING));
    rst = 1'b0;
    tick();

    // 0xA5C3 MSB-first, out_ready held high
    sif.out_ready = 1'b1;
    send_word(16'hA5C3, 1'b1);
    sif.in_valid = 1'b0;
    check("a5c3_valid", 32'(sif.out_valid), 32'd1);
    check("a5c3_word",  32'(sif.out_word),  32'hA5C3);
    tick();
    check("a5c3_valid_drop", 32'(sif.out_valid), 32'd0);

    // LSB-first instance: 1 then fifteen 0s gives 0x0001
    lif.out_ready = 1'b1;
    lif.in_valid  = 1'b1;
    for (int i = 0; i < W; i++) begin
      lif.in_bit = (i == 0);
      tick();
    end
    lif.in_valid = 1'b0;
    check("lsb_valid", 32'(lif.out_valid), 32'd1);
    check("lsb_word",  32'(lif.out_word),  32'h0001);
    tick();

    // stall: 0x1234 held, 0xFFFF streamed behind it
    sif.out_ready = 1'b0;
    send_word(16'h1234, 1'b1);
    sif.in_valid = 1'b0;
    tick();
    check("hold_valid", 32'(sif.out_valid), 32'd1);
    check("hold_word",  32'(sif.out_word),  32'h1234);
    check("hold_state", 32'(sif.state),     32'(ST_HOLDING));
    exp_q.push_back(16'hFFFF);
    for (int i = 0; i < W - 1; i++) send_bit(1'b1);
    check("stall_bit_count", 32'(sif.bit_count), 32'd15);
    check("stall_in_ready",  32'(sif.in_ready),  32'd0);
    check("stall_word",      32'(sif.out_word),  32'h1234);
    check("stall_state",     32'(sif.state),     32'(ST_STALLED));
    tick();
    check("stall_word_stable",  32'(sif.out_word),  32'h1234);
    check("stall_count_stable", 32'(sif.bit_count), 32'd15);
    sif.out_ready = 1'b1;
    #1;
    check("unstall_in_ready", 32'(sif.in_ready), 32'd1);
    tick();
    sif.in_valid = 1'b0;
    check("swap_valid",     32'(sif.out_valid), 32'd1);
    check("swap_word",      32'(sif.out_word),  32'hFFFF);
    check("swap_bit_count", 32'(sif.bit_count), 32'd0);
    tick();
    check("swap_drain_valid", 32'(sif.out_valid), 32'd0);

    // back-to-back words, no stall, outputs 16 cycles apart
    xfer_cyc.delete();
    t0 = cycle_cnt;
    send_word(16'h0F0F, 1'b1);
    send_word(16'hF0F0, 1'b1);
    sif.in_valid = 1'b0;
    check("b2b_cycles", 32'(cycle_cnt - t0), 32'd32);
    tick(); tick();
    check("b2b_xfers", 32'(xfer_cyc.size()), 32'd2);
    if (xfer_cyc.size() == 2)
      check("b2b_spacing", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd16);

    // 7 bits, clear with a bit offered (dropped), then 0xBEEF
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    check("pre_clear_count", 32'(sif.bit_count), 32'd7);
    sif.clear = 1'b1;
    sif.in_valid = 1'b1;
    sif.in_bit = 1'b1;
    #1;
    check("clear_in_ready", 32'(sif.in_ready), 32'd1);
    tick();
    sif.clear = 1'b0;
    sif.in_valid = 1'b0;
    check("post_clear_count", 32'(sif.bit_count), 32'd0);
    check("post_clear_valid", 32'(sif.out_valid), 32'd0);
    send_word(16'hBEEF, 1'b1);
    sif.in_valid = 1'b0;
    check("beef_word", 32'(sif.out_word), 32'hBEEF);
    tick();

    // asynchronous reset mid-word
    for (int i = 0; i < 9; i++) send_bit(i[0]);
    sif.in_valid = 1'b0;
    check("mid_word_count", 32'(sif.bit_count), 32'd9);
    #2 rst = 1'b1;
    #1;
    check("arst_word_count", 32'(sif.bit_count), 32'd0);
    check("arst_word_ready", 32'(sif.in_ready),  32'd1);
    tick();
    rst = 1'b0;
    tick();

    // asynchronous reset mid-hold
    sif.out_ready = 1'b0;
    send_word(16'h5555, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    sif.in_valid = 1'b0;
    check("mid_hold_valid", 32'(sif.out_valid), 32'd1);
    check("mid_hold_word",  32'(sif.out_word),  32'h5555);
    #2 rst = 1'b1;
    #1;
    check("arst_hold_valid", 32'(sif.out_valid), 32'd0);
    check("arst_hold_word",  32'(sif.out_word),  32'd0);
    check("arst_hold_count", 32'(sif.bit_count), 32'd0);
    check("arst_hold_ready", 32'(sif.in_ready),  32'd1);
    tick();
    rst = 1'b0;
    tick();

    // full word after reset
    sif.out_ready = 1'b1;
    send_word(16'h8001, 1'b1);
    sif.in_valid = 1'b0;
    check("w8001_word", 32'(sif.out_word), 32'h8001);
    tick(); tick();
    check("w8001_valid_drop", 32'(sif.out_valid), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
